// File: rtl/btn_conditioner_if.sv
// Button bundle between the board pins and the game logic.
// The master drives the raw pins and the slave returns the conditioned views.
interface btn_conditioner_if #(
  parameter int unsigned N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronise, debounce, and emit a clean level,
// press/auto-repeat pulses and release pulses for each button independently.
module btn_conditioner #(
  parameter int unsigned      N_BTN           = 5,
  parameter int unsigned      DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned      REPEAT_DELAY    = 50_000_000,
  parameter int unsigned      REPEAT_PERIOD   = 15_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b00011
) (
  input  logic              clk,
  input  logic              reset_n,
  btn_conditioner_if.slave  bus
);

  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RP_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W     = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
  localparam int unsigned DB_LAST  = DEBOUNCE_CYCLES - 1;
  localparam int unsigned RD_LAST  = REPEAT_DELAY - 1;
  localparam int unsigned RPR_LAST = REPEAT_PERIOD - 1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_BTN-1:0] sync_a;
  logic [N_BTN-1:0] sync_b;
  logic [N_BTN-1:0] level_vec;
  logic [N_BTN-1:0] press_vec;
  logic [N_BTN-1:0] release_vec;

  // Two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= bus.btn_raw;
      sync_b <= sync_a;
    end
  end

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
    state_t          state;
    logic [DB_W-1:0] db_cnt;
    logic [RP_W-1:0] rp_cnt;
    logic            rp_first;
    logic            level;
    logic            press;
    logic            release_p;
    logic            s;

    assign s = sync_b[i];

    // Debounce FSM; the repeat counter freezes while a release is being qualified
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= IDLE;
        db_cnt    <= '0;
        rp_cnt    <= '0;
        rp_first  <= 1'b1;
        level     <= 1'b0;
        press     <= 1'b0;
        release_p <= 1'b0;
      end else begin
        press     <= 1'b0;
        release_p <= 1'b0;
        unique case (state)
          IDLE: begin
            if (s) begin
              state  <= PRESS_WAIT;
              db_cnt <= DB_W'(1);
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              state  <= IDLE;
              db_cnt <= '0;
            end else if (db_cnt == DB_W'(DB_LAST)) begin
              state    <= HELD;
              db_cnt   <= '0;
              level    <= 1'b1;
              press    <= 1'b1;
              rp_cnt   <= '0;
              rp_first <= 1'b1;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end
          HELD: begin
            if (!s) begin
              state  <= RELEASE_WAIT;
              db_cnt <= DB_W'(1);
            end else if (REPEAT_MASK[i]) begin
              if (rp_cnt == (rp_first ? RP_W'(RD_LAST) : RP_W'(RPR_LAST))) begin
                press    <= 1'b1;
                rp_cnt   <= '0;
                rp_first <= 1'b0;
              end else begin
                rp_cnt <= rp_cnt + RP_W'(1);
              end
            end
          end
          RELEASE_WAIT: begin
            if (s) begin
              state  <= HELD;
              db_cnt <= '0;
            end else if (db_cnt == DB_W'(DB_LAST)) begin
              state     <= IDLE;
              db_cnt    <= '0;
              level     <= 1'b0;
              release_p <= 1'b1;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            db_cnt <= '0;
          end
        endcase
      end
    end

    assign level_vec[i]   = level;
    assign press_vec[i]   = press;
    assign release_vec[i] = release_p;
  end

  assign bus.btn_level   = level_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = release_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus queues expected pulse events,
// a negedge monitor pops and compares whenever a press or release pulse shows.
module tb_btn_conditioner;

  localparam int unsigned N = 5;

  typedef struct {
    int unsigned cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  ev_t exp_q[$];
  int unsigned b = 0;
  int e = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3),
    .REPEAT_MASK(5'b00011)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Scenario-relative edge bookkeeping: edge k lands at absolute cyc b+1+k
  task automatic start();
    b = cyc;
    e = -1;
  endtask

  task automatic at(input int k);
    while (e < k) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic push(input int k, input logic [N-1:0] p, input logic [N-1:0] r);
    ev_t ev;
    ev.cyc   = b + 1 + 32'(k);
    ev.press = p;
    ev.rel   = r;
    exp_q.push_back(ev);
  endtask

  // Monitor: every pulse cycle must match the next queued expectation
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (bus.btn_press != '0 || bus.btn_release != '0)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: press=0x%0h release=0x%0h at cyc %0d, none expected",
                 bus.btn_press, bus.btn_release, cyc);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        check("ev_cycle", 32'(cyc), 32'(ev.cyc));
        check("ev_press", 32'(bus.btn_press), 32'(ev.press));
        check("ev_release", 32'(bus.btn_release), 32'(ev.rel));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [8:0] pat;
    bus.btn_raw = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_level", 32'(bus.btn_level), 32'd0);
    check("rst_press", 32'(bus.btn_press), 32'd0);
    check("rst_release", 32'(bus.btn_release), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Clean press/release on BtnC, no repeat
    start();
    bus.btn_raw[4] = 1'b1;
    push(5, 5'b10000, 5'b00000);
    push(25, 5'b00000, 5'b10000);
    at(4);  check("c_level_pre", 32'(bus.btn_level), 32'd0);
    at(5);  check("c_level_on", 32'(bus.btn_level), 32'h10);
    at(19); bus.btn_raw[4] = 1'b0;
    at(24); check("c_level_hold", 32'(bus.btn_level), 32'h10);
    at(25); check("c_level_off", 32'(bus.btn_level), 32'd0);
    at(35);

    // Bounce rejection on BtnR
    start();
    pat = 9'b111101101;
    for (int k = 0; k < 9; k++) begin
      at(k - 1);
      bus.btn_raw[3] = pat[k];
    end
    push(10, 5'b01000, 5'b00000);
    push(25, 5'b00000, 5'b01000);
    at(9);  check("r_level_bounce", 32'(bus.btn_level), 32'd0);
    at(10); check("r_level_on", 32'(bus.btn_level), 32'h08);
    at(19); bus.btn_raw[3] = 1'b0;
    at(35);

    // Auto-repeat on BtnU
    start();
    bus.btn_raw[0] = 1'b1;
    push(5, 5'b00001, 5'b00000);
    for (int k = 15; k <= 30; k += 3) push(k, 5'b00001, 5'b00000);
    push(35, 5'b00000, 5'b00001);
    at(29); bus.btn_raw[0] = 1'b0;
    at(45);

    // Release glitch on BtnD: repeat counter frozen for three edges
    start();
    bus.btn_raw[1] = 1'b1;
    push(5, 5'b00010, 5'b00000);
    for (int k = 18; k <= 30; k += 3) push(k, 5'b00010, 5'b00000);
    push(35, 5'b00000, 5'b00010);
    at(11); bus.btn_raw[1] = 1'b0;
    at(13); bus.btn_raw[1] = 1'b1;
    at(15); check("d_level_glitch", 32'(bus.btn_level), 32'h02);
    at(16); check("d_level_back", 32'(bus.btn_level), 32'h02);
    at(29); bus.btn_raw[1] = 1'b0;
    at(45);

    // Simultaneous U and L: same-cycle press, only U repeats
    start();
    bus.btn_raw[0] = 1'b1;
    bus.btn_raw[2] = 1'b1;
    push(5, 5'b00101, 5'b00000);
    for (int k = 15; k <= 24; k += 3) push(k, 5'b00001, 5'b00000);
    push(30, 5'b00000, 5'b00101);
    at(5);  check("ul_level", 32'(bus.btn_level), 32'h05);
    at(24); bus.btn_raw[0] = 1'b0; bus.btn_raw[2] = 1'b0;
    at(40);

    // Reset mid-hold on BtnU, then fresh press after release of reset
    start();
    bus.btn_raw[0] = 1'b1;
    push(5, 5'b00001, 5'b00000);
    at(8);  check("u_level_pre_rst", 32'(bus.btn_level), 32'h01);
    at(11);
    reset_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(bus.btn_level), 32'd0);
    check("mid_rst_release", 32'(bus.btn_release), 32'd0);
    at(13);
    reset_n = 1'b1;
    start();
    push(5, 5'b00001, 5'b00000);
    push(13, 5'b00000, 5'b00001);
    at(4);  check("post_rst_level_pre", 32'(bus.btn_level), 32'd0);
    at(7);  bus.btn_raw[0] = 1'b0;
    at(25);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
